// File: rtl/rvvi_pkg.sv
// Shared definitions for the RVVI receive path: FSM encoding, header layout and header compare.
package rvvi_pkg;

  typedef logic [1:0] rvvi_rx_state_t;

  localparam rvvi_rx_state_t ST_IDLE    = 2'd0;
  localparam rvvi_rx_state_t ST_HDR     = 2'd1;
  localparam rvvi_rx_state_t ST_PAYLOAD = 2'd2;
  localparam rvvi_rx_state_t ST_DRAIN   = 2'd3;

  // Beats 0..3 carry the Ethernet header; payload starts at beat HDR_BEATS.
  localparam int unsigned HDR_BEATS   = 4;
  // SubType occupies the upper half of header beat 3, EtherType the lower half.
  localparam int unsigned SUBTYPE_LSB = 16;

  // Compare one header beat against the expected MAC/EtherType layout.
  function automatic logic hdr_match(input logic [1:0]  idx,
                                     input logic [31:0] data,
                                     input logic [47:0] dst,
                                     input logic [47:0] src,
                                     input logic [15:0] eth);
    logic ok;
    case (idx)
      2'd0:    ok = (data == dst[31:0]);
      2'd1:    ok = (data == {src[15:0], dst[47:32]});
      2'd2:    ok = (data == src[47:16]);
      default: ok = (data[15:0] == eth);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rvvi_pulse_stretch.sv
// Restartable pulse stretcher: a hit holds pulse high for TRIG_LEN cycles starting next cycle.
module rvvi_pulse_stretch #(
  parameter int unsigned TRIG_LEN = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic hit,
  output logic pulse
);

  localparam int unsigned CW = $clog2(TRIG_LEN + 1);

  logic [CW-1:0] remain;

  // Down-counter; a new hit reloads the full length even mid-pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      remain <= '0;
    end else if (hit) begin
      remain <= CW'(TRIG_LEN);
    end else if (remain != '0) begin
      remain <= remain - 1'b1;
    end
  end

  assign pulse = (remain != '0);

endmodule

// File: rtl/rvvi_frame_parser.sv
// Receive-side RVVI Ethernet frame parser: header match, subtype classification, payload capture
// with valid/ready output, sequence checking, runt/overflow statistics and a stretched ILA trigger.
module rvvi_frame_parser
  import rvvi_pkg::*;
#(
  parameter int unsigned NUM_TYPES     = 4,
  parameter int unsigned PAYLOAD_WORDS = 8,
  parameter int unsigned TRIG_WORDS    = 5,
  parameter int unsigned TRIG_LEN      = 10,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [31:0]                  RvviAxiRdata,
  input  logic                         RvviAxiRvalid,
  input  logic                         RvviAxiRlast,
  input  logic [47:0]                  DstMac,
  input  logic [47:0]                  SrcMac,
  input  logic [15:0]                  EthType,
  input  logic [16*NUM_TYPES-1:0]      TypeTable,
  input  logic [15:0]                  TriggerType,
  input  logic [32*TRIG_WORDS-1:0]     TriggerString,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [NUM_TYPES-1:0]         OutType,
  output logic [32*PAYLOAD_WORDS-1:0]  OutPayload,
  output logic [63:0]                  FrameCount,
  output logic                         SeqError,
  output logic [CNT_W-1:0]             RuntCount,
  output logic [CNT_W-1:0]             OverflowCount,
  output logic                         IlaTrigger
);

  // Counter saturates above the last payload index so long frames cannot wrap it.
  localparam int unsigned BEAT_CNT_W = $clog2(HDR_BEATS + PAYLOAD_WORDS + 1) + 1;
  localparam logic [BEAT_CNT_W-1:0] BEAT_MAX     = '1;
  localparam logic [BEAT_CNT_W-1:0] LAST_HDR     = BEAT_CNT_W'(HDR_BEATS - 1);
  localparam logic [BEAT_CNT_W-1:0] LAST_PAYLOAD = BEAT_CNT_W'(HDR_BEATS + PAYLOAD_WORDS - 1);
  localparam logic [BEAT_CNT_W-1:0] LAST_TRIG    = BEAT_CNT_W'(HDR_BEATS + 1 + TRIG_WORDS);

  rvvi_rx_state_t            state, state_next;
  logic [BEAT_CNT_W-1:0]     beat, beat_next;
  logic [NUM_TYPES-1:0]      chan, chan_next;
  logic                      trig_arm, trig_arm_next;
  logic                      trig_ok, trig_ok_next;
  logic                      have_prev;
  logic [31:0]               stage [PAYLOAD_WORDS];
  logic [31:0]               words [PAYLOAD_WORDS];
  logic [32*PAYLOAD_WORDS-1:0] words_flat;
  logic [15:0]               sub_type;
  logic [NUM_TYPES-1:0]      type_hit;
  logic [NUM_TYPES-1:0]      frame_chan;
  logic                      beat_ok, trig_beat_ok, type_found;
  logic                      frame_end, complete, accept, load, runt_inc, ovf_inc, trig_hit;
  logic [63:0]               new_count;

  assign sub_type = RvviAxiRdata[SUBTYPE_LSB +: 16];
  assign beat_ok  = hdr_match(beat[1:0], RvviAxiRdata, DstMac, SrcMac, EthType);

  // Subtype lookup; the lowest matching channel wins on duplicate table entries.
  always_comb begin
    type_hit   = '0;
    type_found = 1'b0;
    for (int i = 0; i < NUM_TYPES; i++) begin
      if (!type_found && sub_type == TypeTable[16*i +: 16]) begin
        type_hit[i] = 1'b1;
        type_found  = 1'b1;
      end
    end
  end

  // Trigger-string compare for the current beat (payload words 2..TRIG_WORDS+1).
  always_comb begin
    trig_beat_ok = 1'b1;
    for (int k = 0; k < TRIG_WORDS; k++) begin
      if (beat == BEAT_CNT_W'(HDR_BEATS + 2 + k) && RvviAxiRdata != TriggerString[32*k +: 32]) begin
        trig_beat_ok = 1'b0;
      end
    end
  end

  // Staged payload with the current beat merged in, so the last payload beat can also be Rlast.
  always_comb begin
    for (int k = 0; k < PAYLOAD_WORDS; k++) begin
      words[k] = stage[k];
      if (state == ST_PAYLOAD && beat == BEAT_CNT_W'(HDR_BEATS + k)) begin
        words[k] = RvviAxiRdata;
      end
      words_flat[32*k +: 32] = words[k];
    end
  end

  // Frame-end classification; frame_chan covers a frame whose Rlast is header beat 3 itself.
  assign frame_chan = (state == ST_HDR && beat == LAST_HDR && beat_ok) ? type_hit : chan;
  assign complete   = (|chan) && (beat >= LAST_PAYLOAD);
  assign frame_end  = RvviAxiRvalid && RvviAxiRlast;
  assign accept     = frame_end && complete;
  assign load       = accept && (!OutValid || OutReady);
  assign ovf_inc    = accept && !load;
  assign runt_inc   = frame_end && (|frame_chan) && !complete;
  assign trig_hit   = frame_end && trig_arm && trig_ok && trig_beat_ok && (beat >= LAST_TRIG);
  assign new_count  = {words[1], words[0]};

  // Receive FSM next state; only valid beats advance, Rlast always returns to IDLE.
  always_comb begin
    state_next    = state;
    beat_next     = beat;
    chan_next     = chan;
    trig_arm_next = trig_arm;
    trig_ok_next  = trig_ok;
    if (RvviAxiRvalid) begin
      if (beat != BEAT_MAX) beat_next = beat + 1'b1;
      trig_ok_next = trig_ok & trig_beat_ok;
      unique case (state)
        ST_IDLE: begin
          trig_ok_next = 1'b1;
          state_next   = beat_ok ? ST_HDR : ST_DRAIN;
        end
        ST_HDR: begin
          if (!beat_ok) begin
            state_next = ST_DRAIN;
          end else if (beat == LAST_HDR) begin
            chan_next     = type_hit;
            trig_arm_next = (sub_type == TriggerType);
            state_next    = (|type_hit) ? ST_PAYLOAD : ST_DRAIN;
          end
        end
        ST_PAYLOAD: begin
          if (beat == LAST_PAYLOAD) state_next = ST_DRAIN;
        end
        default: state_next = state;
      endcase
      if (RvviAxiRlast) begin
        state_next    = ST_IDLE;
        beat_next     = '0;
        chan_next     = '0;
        trig_arm_next = 1'b0;
        trig_ok_next  = 1'b0;
      end
    end
  end

  // Per-frame parse state and payload staging.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      beat     <= '0;
      chan     <= '0;
      trig_arm <= 1'b0;
      trig_ok  <= 1'b0;
      for (int k = 0; k < PAYLOAD_WORDS; k++) stage[k] <= '0;
    end else begin
      state    <= state_next;
      beat     <= beat_next;
      chan     <= chan_next;
      trig_arm <= trig_arm_next;
      trig_ok  <= trig_ok_next;
      if (RvviAxiRvalid) begin
        for (int k = 0; k < PAYLOAD_WORDS; k++) stage[k] <= words[k];
      end
    end
  end

  // Output holding register, frame count and sticky sequence check.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      OutValid   <= 1'b0;
      OutType    <= '0;
      OutPayload <= '0;
      FrameCount <= '0;
      SeqError   <= 1'b0;
      have_prev  <= 1'b0;
    end else if (load) begin
      OutValid   <= 1'b1;
      OutType    <= chan;
      OutPayload <= words_flat;
      FrameCount <= new_count;
      have_prev  <= 1'b1;
      // 64-bit wrap from all-ones to zero is a legal successor.
      if (have_prev && new_count != FrameCount + 64'd1) SeqError <= 1'b1;
    end else if (OutValid && OutReady) begin
      OutValid <= 1'b0;
    end
  end

  // Saturating runt/overflow statistics.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      RuntCount     <= '0;
      OverflowCount <= '0;
    end else begin
      if (runt_inc && RuntCount != {CNT_W{1'b1}}) RuntCount <= RuntCount + 1'b1;
      if (ovf_inc && OverflowCount != {CNT_W{1'b1}}) OverflowCount <= OverflowCount + 1'b1;
    end
  end

  rvvi_pulse_stretch #(
    .TRIG_LEN (TRIG_LEN)
  ) u_trig_stretch (
    .clk    (clk),
    .resetn (resetn),
    .hit    (trig_hit),
    .pulse  (IlaTrigger)
  );

endmodule

// File: tb/tb_rvvi_frame_parser.sv
// Self-checking bench for rvvi_frame_parser: frame-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized frames.
module tb_rvvi_frame_parser;

  localparam int NT = 4;
  localparam int PW = 8;
  localparam int TW = 5;
  localparam int TL = 10;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [31:0] rdata = '0;
  logic rvalid = 1'b0;
  logic rlast = 1'b0;
  logic out_ready = 1'b1;
  logic [47:0] dst_mac = 48'h0011_2233_4455;
  logic [47:0] src_mac = 48'h6677_8899_AABB;
  logic [15:0] eth_type = 16'h88B5;
  // ch0=0A01, ch1=0B02, ch2=0C03, ch3=0B02 (duplicate of ch1, never selected)
  logic [16*NT-1:0] type_table = {16'h0B02, 16'h0C03, 16'h0B02, 16'h0A01};
  logic [15:0] trig_type = 16'h0A01;
  logic [32*TW-1:0] trig_str = {32'h5452_4947, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D,
                                32'h0BAD_C0DE};

  logic              out_valid;
  logic [NT-1:0]     out_type;
  logic [32*PW-1:0]  out_payload;
  logic [63:0]       frame_count;
  logic              seq_error;
  logic [CW-1:0]     runt_count;
  logic [CW-1:0]     ovf_count;
  logic              ila_trigger;

  int n_tests = 0;
  int n_fail = 0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  rvvi_frame_parser #(
    .NUM_TYPES     (NT),
    .PAYLOAD_WORDS (PW),
    .TRIG_WORDS    (TW),
    .TRIG_LEN      (TL),
    .CNT_W         (CW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .RvviAxiRdata  (rdata),
    .RvviAxiRvalid (rvalid),
    .RvviAxiRlast  (rlast),
    .DstMac        (dst_mac),
    .SrcMac        (src_mac),
    .EthType       (eth_type),
    .TypeTable     (type_table),
    .TriggerType   (trig_type),
    .TriggerString (trig_str),
    .OutValid      (out_valid),
    .OutReady      (out_ready),
    .OutType       (out_type),
    .OutPayload    (out_payload),
    .FrameCount    (frame_count),
    .SeqError      (seq_error),
    .RuntCount     (runt_count),
    .OverflowCount (ovf_count),
    .IlaTrigger    (ila_trigger)
  );

  // ---------------- reference model (whole-frame evaluation) ----------------
  logic [31:0]      cur[$];
  logic             m_valid = 1'b0;
  logic [NT-1:0]    m_type = '0;
  logic [32*PW-1:0] m_payload = '0;
  logic [63:0]      m_count = '0;
  logic             m_seq = 1'b0;
  logic             m_have_prev = 1'b0;
  logic [CW-1:0]    m_runt = '0;
  logic [CW-1:0]    m_ovf = '0;
  int               m_trig_rem = 0;
  int               m_n, m_ch;
  bit               m_hdr, m_hit, m_loaded, m_hs;
  logic [63:0]      m_cnt;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur.delete();
      m_valid = 1'b0; m_type = '0; m_payload = '0; m_count = '0; m_seq = 1'b0;
      m_have_prev = 1'b0; m_runt = '0; m_ovf = '0; m_trig_rem = 0;
    end else begin
      m_hs = m_valid && out_ready;
      m_hit = 1'b0;
      m_loaded = 1'b0;
      if (rvalid) begin
        cur.push_back(rdata);
        if (rlast) begin
          m_n = cur.size();
          m_hdr = 1'b0;
          if (m_n >= 4)
            m_hdr = cur[0] == dst_mac[31:0] && cur[1] == {src_mac[15:0], dst_mac[47:32]} &&
                    cur[2] == src_mac[47:16] && cur[3][15:0] == eth_type;
          m_ch = -1;
          if (m_hdr)
            for (int i = NT - 1; i >= 0; i--)
              if (cur[3][31:16] == type_table[16*i +: 16]) m_ch = i;
          if (m_hdr && m_ch >= 0) begin
            if (m_n >= 4 + PW) begin
              if (!m_valid || out_ready) begin
                m_valid = 1'b1;
                m_type = '0;
                m_type[m_ch] = 1'b1;
                for (int k = 0; k < PW; k++) m_payload[32*k +: 32] = cur[4+k];
                m_cnt = {cur[5], cur[4]};
                if (m_have_prev && m_cnt != m_count + 64'd1) m_seq = 1'b1;
                m_count = m_cnt;
                m_have_prev = 1'b1;
                m_loaded = 1'b1;
              end else if (m_ovf != {CW{1'b1}}) begin
                m_ovf = m_ovf + 1'b1;
              end
            end else if (m_runt != {CW{1'b1}}) begin
              m_runt = m_runt + 1'b1;
            end
          end
          if (m_hdr && cur[3][31:16] == trig_type && m_n >= 6 + TW) begin
            m_hit = 1'b1;
            for (int k = 0; k < TW; k++) if (cur[6+k] != trig_str[32*k +: 32]) m_hit = 1'b0;
          end
          cur.delete();
        end
      end
      if (!m_loaded && m_hs) m_valid = 1'b0;
      if (m_hit) m_trig_rem = TL;
      else if (m_trig_rem > 0) m_trig_rem = m_trig_rem - 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (resetn) begin
      n_tests++;
      if (out_valid !== m_valid || out_type !== m_type || frame_count !== m_count ||
          seq_error !== m_seq || runt_count !== m_runt || ovf_count !== m_ovf ||
          ila_trigger !== (m_trig_rem > 0) || (m_valid && out_payload !== m_payload)) begin
        n_fail++;
        $display("FAIL cycle_cmp @%0t: dut v=%b t=%b cnt=%h seq=%b runt=%0d ovf=%0d trg=%b pl=%h; model v=%b t=%b cnt=%h seq=%b runt=%0d ovf=%0d trg=%b pl=%h",
                 $time, out_valid, out_type, frame_count, seq_error, runt_count, ovf_count,
                 ila_trigger, out_payload, m_valid, m_type, m_count, m_seq, m_runt, m_ovf,
                 m_trig_rem > 0, m_payload);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] fr[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic make_frame(input logic [15:0] sub, input logic [63:0] cnt, input int nbeats,
                            input bit trig_good);
    logic [31:0] full[$];
    full = {};
    full.push_back(dst_mac[31:0]);
    full.push_back({src_mac[15:0], dst_mac[47:32]});
    full.push_back(src_mac[47:16]);
    full.push_back({sub, eth_type});
    full.push_back(cnt[31:0]);
    full.push_back(cnt[63:32]);
    for (int k = 0; k < TW; k++) full.push_back(trig_good ? trig_str[32*k +: 32] : $urandom);
    while (full.size() < nbeats) full.push_back($urandom);
    fr = {};
    for (int i = 0; i < nbeats; i++) fr.push_back(full[i]);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    rvalid = 1'b0;
    rlast = 1'($urandom_range(0, 1));
    rdata = $urandom;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Sends beats 0..stop-1 of fr; Rlast only if the whole frame is sent.
  task automatic send_frame(input int gap, input int stop);
    for (int i = 0; i < stop; i++) begin
      repeat ($urandom_range(0, gap)) idle_cycle();
      @(posedge clk); #1;
      rvalid = 1'b1;
      rdata = fr[i];
      rlast = (i == fr.size() - 1);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rvalid = 1'b0;
    rlast = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int hi;
  logic [63:0] next_cnt;
  int kind, idx;

  initial begin
    // Reset state
    repeat (3) step();
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_runt", 64'(runt_count), 64'd0);
    chk("reset_ovf", 64'(ovf_count), 64'd0);
    chk("reset_count", frame_count, 64'd0);
    resetn = 1'b1;
    step();

    // 1: matching frame on channel 2, count 5
    out_ready = 1'b1;
    make_frame(16'h0C03, 64'd5, 12, 1'b0);
    send_frame(0, fr.size());
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_type", 64'(out_type), 64'b0100);
    chk("t1_word0", 64'(out_payload[31:0]), 64'd5);
    step();
    chk("t1_valid_drop", 64'(out_valid), 64'd0);

    // 2: DstMac mismatch dropped silently, then good frame
    make_frame(16'h0C03, 64'd6, 12, 1'b0);
    fr[0] = fr[0] ^ 32'h1;
    send_frame(1, fr.size());
    chk("t2_no_valid", 64'(out_valid), 64'd0);
    chk("t2_runt", 64'(runt_count), 64'd0);
    chk("t2_ovf", 64'(ovf_count), 64'd0);
    make_frame(16'h0B02, 64'd6, 12, 1'b0);
    send_frame(1, fr.size());
    chk("t2_good_valid", 64'(out_valid), 64'd1);
    chk("t2_good_type", 64'(out_type), 64'b0010);
    chk("t2_good_count", frame_count, 64'd6);
    step();

    // 3: runt, Rlast at beat 6
    make_frame(16'h0A01, 64'd100, 7, 1'b0);
    send_frame(0, fr.size());
    chk("t3_runt", 64'(runt_count), 64'd1);
    chk("t3_no_valid", 64'(out_valid), 64'd0);

    // 4: overflow while held, then sequence gap 7 -> 9
    out_ready = 1'b0;
    make_frame(16'h0A01, 64'd7, 12, 1'b0);
    send_frame(0, fr.size());
    chk("t4_held_count", frame_count, 64'd7);
    chk("t4_seq_ok", 64'(seq_error), 64'd0);
    make_frame(16'h0A01, 64'd8, 12, 1'b0);
    send_frame(0, fr.size());
    chk("t4_ovf", 64'(ovf_count), 64'd1);
    chk("t4_held_word0", 64'(out_payload[31:0]), 64'd7);
    out_ready = 1'b1;
    step();
    make_frame(16'h0A01, 64'd9, 13, 1'b0);
    send_frame(0, fr.size());
    chk("t4_count9", frame_count, 64'd9);
    chk("t4_seq_err", 64'(seq_error), 64'd1);

    // 5: trigger frame, pulse length; corrupted string gives no pulse
    make_frame(16'h0A01, 64'd10, 12, 1'b1);
    send_frame(0, fr.size());
    hi = 0;
    repeat (30) begin
      if (ila_trigger) hi++;
      step();
    end
    chk("t5_trig_len", 64'(hi), 64'd10);
    make_frame(16'h0A01, 64'd11, 12, 1'b1);
    fr[6 + TW - 1] = fr[6 + TW - 1] ^ 32'h8000_0000;
    send_frame(0, fr.size());
    hi = 0;
    repeat (20) begin
      if (ila_trigger) hi++;
      step();
    end
    chk("t5_no_trig", 64'(hi), 64'd0);

    // 6: reset mid-payload while holding a frame
    out_ready = 1'b0;
    make_frame(16'h0C03, 64'd12, 12, 1'b0);
    send_frame(0, fr.size());
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    make_frame(16'h0C03, 64'd13, 12, 1'b0);
    send_frame(0, 7);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_type", 64'(out_type), 64'd0);
    chk("t6_rst_count", frame_count, 64'd0);
    chk("t6_rst_runt", 64'(runt_count), 64'd0);
    chk("t6_rst_payload", out_payload[63:0], 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    out_ready = 1'b1;
    // 64-bit wrap is a legal successor
    make_frame(16'h0C03, 64'hFFFF_FFFF_FFFF_FFFF, 12, 1'b0);
    send_frame(0, fr.size());
    chk("t6_after_valid", 64'(out_valid), 64'd1);
    make_frame(16'h0C03, 64'd0, 12, 1'b0);
    send_frame(0, fr.size());
    chk("wrap_count", frame_count, 64'd0);
    chk("wrap_seq", 64'(seq_error), 64'd0);

    // Randomized frames checked by the model every cycle
    rand_ready = 1'b1;
    next_cnt = 64'd1;
    for (int f = 0; f < 400; f++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 19) == 0) next_cnt = next_cnt + 64'd2;
      case (kind)
        0, 1, 2, 3, 4: begin
          make_frame(type_table[16*$urandom_range(0, NT-1) +: 16], next_cnt,
                     4 + PW + $urandom_range(0, 3), 1'b0);
          next_cnt = next_cnt + 64'd1;
        end
        5: make_frame(16'h0B02, next_cnt, $urandom_range(1, 4 + PW - 1), 1'b0);
        6: begin
          make_frame(16'h0C03, next_cnt, 4 + PW, 1'b0);
          idx = $urandom_range(0, 3);
          fr[idx] = fr[idx] ^ (32'h1 << $urandom_range(0, 31));
        end
        7: begin
          make_frame(trig_type, next_cnt, 4 + PW + $urandom_range(0, 2), 1'b1);
          next_cnt = next_cnt + 64'd1;
          if ($urandom_range(0, 1) == 1) begin
            idx = 6 + $urandom_range(0, TW - 1);
            fr[idx] = fr[idx] ^ 32'h10;
          end
        end
        8: make_frame(16'hFFFF, next_cnt, 4 + PW, 1'b0);
        default: begin
          make_frame(16'h0A01, next_cnt, 4 + PW, 1'b0);
          fr[3] = fr[3] ^ 32'h0000_0100;
        end
      endcase
      send_frame(2, fr.size());
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
